// File: rtl/dvga_multisprite_rend.sv
// Multi-sprite overlay: composites up to NSPR square sprites onto an RGB stream.
// Positions and controls are shadowed at the vsync rise. Colour and timing pass
// through a 3-stage pipeline, and sticky collision flags raise an interrupt.
`timescale 1ns/1ps
module dvga_multisprite_rend #(
  parameter int unsigned NSPR  = 4,
  parameter int unsigned SPRLW = 5,
  parameter int unsigned XCNTW = 11,
  parameter int unsigned YCNTW = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [XCNTW-1:0]          xpos_i,
  input  logic [YCNTW-1:0]          ypos_i,
  input  logic [7:0]                r_i,
  input  logic [7:0]                g_i,
  input  logic [7:0]                b_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      blank_i,
  output logic [XCNTW-1:0]          xpos_o,
  output logic [YCNTW-1:0]          ypos_o,
  output logic [7:0]                r_o,
  output logic [7:0]                g_o,
  output logic [7:0]                b_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      blank_o,
  input  logic [NSPR-1:0]           spren_i,
  input  logic [NSPR-1:0]           hflip_i,
  input  logic [NSPR-1:0]           vflip_i,
  input  logic [2:0]                swapcolor_i,
  input  logic [NSPR*XCNTW-1:0]     sprx_i,
  input  logic [NSPR*YCNTW-1:0]     spry_i,
  input  logic [NSPR*SPRLW-1:0]     sproffsx_i,
  input  logic [NSPR*SPRLW-1:0]     sproffsy_i,
  output logic [NSPR*2*SPRLW-1:0]   spradr_o,
  input  logic [NSPR*16-1:0]        sprdat_i,
  input  logic                      coll_clr_i,
  output logic [NSPR-1:0]           coll_o,
  output logic                      irq_o
);

  localparam int unsigned XW1  = XCNTW + 1;
  localparam int unsigned YW1  = YCNTW + 1;
  localparam int unsigned SPRW = 1 << SPRLW;

  // Shadowed sprite controls
  logic                  vs_prev_q, vs_prev_d;
  logic [NSPR-1:0]       en_q, en_d, hflip_q, hflip_d, vflip_q, vflip_d;
  logic [NSPR*XCNTW-1:0] sprx_q, sprx_d;
  logic [NSPR*YCNTW-1:0] spry_q, spry_d;
  logic [NSPR*SPRLW-1:0] offx_q, offx_d, offy_q, offy_d;
  // Pipeline state; timing vectors are {hsync, vsync, blank}
  logic [NSPR-1:0]       hit1_q, hit1_d;
  logic [23:0]           rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic [2:0]            tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
  logic                  any2_q, any2_d;
  logic [14:0]           pix2_q, pix2_d;
  logic [7:0]            r_q, r_d, g_q, g_d, b_q, b_d;
  logic [NSPR-1:0]       coll_q, coll_d;
  logic                  irq_q, irq_d;
  logic [XCNTW-1:0]      xpos_q, xpos_d;
  logic [YCNTW-1:0]      ypos_q, ypos_d;
  // Combinational helpers
  logic [NSPR-1:0]       inside_c, op_c;
  logic [XW1-1:0]        dx_c;
  logic [YW1-1:0]        dy_c;
  logic [SPRLW-1:0]      col_c, row_c;
  logic [14:0]           win_c;
  logic [3:0]            cnt_c;

  // Per-sprite hit test and RAM address, from the current pixel and the shadows
  always_comb begin
    inside_c = '0;
    spradr_o = '0;
    dx_c     = '0;
    dy_c     = '0;
    col_c    = '0;
    row_c    = '0;
    for (int i = 0; i < int'(NSPR); i++) begin
      dx_c = XW1'(xpos_i) - XW1'(sprx_q[i*XCNTW +: XCNTW]) + XW1'(offx_q[i*SPRLW +: SPRLW]);
      dy_c = YW1'(ypos_i) - YW1'(spry_q[i*YCNTW +: YCNTW]) + YW1'(offy_q[i*SPRLW +: SPRLW]);
      inside_c[i] = (dx_c < XW1'(SPRW)) && (dy_c < YW1'(SPRW));
      // Mirroring is 2^SPRLW-1-v, which is the bitwise complement
      col_c = hflip_q[i] ? ~dx_c[SPRLW-1:0] : dx_c[SPRLW-1:0];
      row_c = vflip_q[i] ? ~dy_c[SPRLW-1:0] : dy_c[SPRLW-1:0];
      spradr_o[i*2*SPRLW +: 2*SPRLW] = {row_c, col_c};
    end
  end

  // Next-state: shadow load, pipeline stages, priority select, collision flags
  always_comb begin
    vs_prev_d = vsync_i;
    en_d      = en_q;
    hflip_d   = hflip_q;
    vflip_d   = vflip_q;
    sprx_d    = sprx_q;
    spry_d    = spry_q;
    offx_d    = offx_q;
    offy_d    = offy_q;
    op_c      = '0;
    win_c     = '0;
    cnt_c     = '0;

    if (vsync_i && !vs_prev_q) begin
      en_d    = spren_i;
      hflip_d = hflip_i;
      vflip_d = vflip_i;
      sprx_d  = sprx_i;
      spry_d  = spry_i;
      offx_d  = sproffsx_i;
      offy_d  = sproffsy_i;
    end

    // Stage 1
    hit1_d = inside_c & en_q;
    rgb1_d = {r_i, g_i, b_i};
    tim1_d = {hsync_i, vsync_i, blank_i};
    xpos_d = xpos_i;
    ypos_d = ypos_i;

    // Stage 2: descending scan so the lowest opaque index wins
    for (int i = int'(NSPR) - 1; i >= 0; i--) begin
      op_c[i] = hit1_q[i] & sprdat_i[16*i+15];
      cnt_c   = cnt_c + 4'(op_c[i]);
      if (op_c[i]) win_c = sprdat_i[16*i +: 15];
    end
    any2_d = |op_c;
    pix2_d = any2_d ? (win_c ^ {{5{swapcolor_i[2]}}, {5{swapcolor_i[1]}}, {5{swapcolor_i[0]}}})
                    : 15'd0;
    rgb2_d = rgb1_q;
    tim2_d = tim1_q;

    // Collision: new bits win over a simultaneous clear
    coll_d = coll_clr_i ? '0 : coll_q;
    if (!tim1_q[0] && (cnt_c >= 4'd2)) coll_d = coll_d | op_c;
    irq_d = |coll_d;

    // Stage 3: 5-bit to 8-bit replication, blank forces black
    tim3_d = tim2_q;
    if (tim2_q[0]) begin
      r_d = 8'd0;
      g_d = 8'd0;
      b_d = 8'd0;
    end else if (any2_q) begin
      r_d = {pix2_q[14:10], pix2_q[14:12]};
      g_d = {pix2_q[9:5],   pix2_q[9:7]};
      b_d = {pix2_q[4:0],   pix2_q[4:2]};
    end else begin
      r_d = rgb2_q[23:16];
      g_d = rgb2_q[15:8];
      b_d = rgb2_q[7:0];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      en_q      <= '0;
      hflip_q   <= '0;
      vflip_q   <= '0;
      sprx_q    <= '0;
      spry_q    <= '0;
      offx_q    <= '0;
      offy_q    <= '0;
      hit1_q    <= '0;
      rgb1_q    <= '0;
      tim1_q    <= '0;
      any2_q    <= 1'b0;
      pix2_q    <= '0;
      rgb2_q    <= '0;
      tim2_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      tim3_q    <= '0;
      coll_q    <= '0;
      irq_q     <= 1'b0;
      xpos_q    <= '0;
      ypos_q    <= '0;
    end else begin
      vs_prev_q <= vs_prev_d;
      en_q      <= en_d;
      hflip_q   <= hflip_d;
      vflip_q   <= vflip_d;
      sprx_q    <= sprx_d;
      spry_q    <= spry_d;
      offx_q    <= offx_d;
      offy_q    <= offy_d;
      hit1_q    <= hit1_d;
      rgb1_q    <= rgb1_d;
      tim1_q    <= tim1_d;
      any2_q    <= any2_d;
      pix2_q    <= pix2_d;
      rgb2_q    <= rgb2_d;
      tim2_q    <= tim2_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      tim3_q    <= tim3_d;
      coll_q    <= coll_d;
      irq_q     <= irq_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
    end
  end

  assign xpos_o  = xpos_q;
  assign ypos_o  = ypos_q;
  assign r_o     = r_q;
  assign g_o     = g_q;
  assign b_o     = b_q;
  assign hsync_o = tim3_q[2];
  assign vsync_o = tim3_q[1];
  assign blank_o = tim3_q[0];
  assign coll_o  = coll_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_dvga_multisprite_rend.sv
// Directed bench for dvga_multisprite_rend with a 1-cycle registered sprite RAM model.
`timescale 1ns/1ps
module tb_dvga_multisprite_rend;

  localparam int unsigned NSPR = 4, SPRLW = 5, XCNTW = 11, YCNTW = 10;
  localparam logic [23:0] BG  = 24'h123456;
  localparam logic [23:0] RED = 24'hFF0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [XCNTW-1:0] xpos_i = '0, xpos_o;
  logic [YCNTW-1:0] ypos_i = '0, ypos_o;
  logic [7:0] r_i = 8'h12, g_i = 8'h34, b_i = 8'h56, r_o, g_o, b_o;
  logic hsync_i = 0, vsync_i = 0, blank_i = 0, hsync_o, vsync_o, blank_o;
  logic [NSPR-1:0] spren_i = '0, hflip_i = '0, vflip_i = '0, coll_o;
  logic [2:0] swapcolor_i = '0;
  logic [NSPR*XCNTW-1:0] sprx_i = '0;
  logic [NSPR*YCNTW-1:0] spry_i = '0;
  logic [NSPR*SPRLW-1:0] sproffsx_i = '0, sproffsy_i = '0;
  logic [NSPR*2*SPRLW-1:0] spradr_o;
  logic [NSPR*16-1:0] sprdat_i = '0;
  logic coll_clr_i = 0, irq_o;
  logic [15:0] ram_val [NSPR];

  int checks = 0, errors = 0;
  logic [23:0] exp_rgb [48];
  logic [2:0]  exp_tim [48];

  dvga_multisprite_rend #(.NSPR(NSPR), .SPRLW(SPRLW), .XCNTW(XCNTW), .YCNTW(YCNTW)) dut (
    .clk(clk), .rst_n(rst_n), .xpos_i(xpos_i), .ypos_i(ypos_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i),
    .xpos_o(xpos_o), .ypos_o(ypos_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
    .spren_i(spren_i), .hflip_i(hflip_i), .vflip_i(vflip_i), .swapcolor_i(swapcolor_i),
    .sprx_i(sprx_i), .spry_i(spry_i), .sproffsx_i(sproffsx_i), .sproffsy_i(sproffsy_i),
    .spradr_o(spradr_o), .sprdat_i(sprdat_i), .coll_clr_i(coll_clr_i),
    .coll_o(coll_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Sprite RAM: one word per sprite for every address, registered read
  always @(posedge clk)
    for (int i = 0; i < int'(NSPR); i++) sprdat_i[16*i +: 16] <= ram_val[i];

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic vs_pulse();
    vsync_i = 1'b1; tick();
    vsync_i = 1'b0; tick();
  endtask

  // Hold one pixel for the full pipeline depth, then check the colour
  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    xpos_i = XCNTW'(x); ypos_i = YCNTW'(y);
    tick(3);
    chk(tag, {8'h0, r_o, g_o, b_o}, {8'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < int'(NSPR); i++) ram_val[i] = 16'h0000;
    // Reset state
    #12;
    chk("rst_rgb", {8'h0, r_o, g_o, b_o}, 32'h0);
    chk("rst_misc", {xpos_o, ypos_o, hsync_o, vsync_o, blank_o, coll_o, irq_o},
        {XCNTW'(0), YCNTW'(0), 3'b0, 4'b0, 1'b0});
    rst_n = 1'b1;
    tick(3);
    chk("idle_bg", {8'h0, r_o, g_o, b_o}, {8'h0, BG});

    // Sprite 0 at (100,50), scan line 50 from x=96 to x=135
    ram_val[0] = 16'hFC00;
    spren_i = 4'b0001;
    sprx_i[0 +: XCNTW] = 11'd100;
    spry_i[0 +: YCNTW] = 10'd50;
    vs_pulse();
    ypos_i = 10'd50;
    for (int k = 0; k < 42; k++) begin
      if (k < 40) begin
        xpos_i  = XCNTW'(96 + k);
        hsync_i = k[0];
        blank_i = (k == 20);
        exp_rgb[k] = (k == 20) ? 24'h0 : ((96 + k >= 100 && 96 + k <= 131) ? RED : BG);
        exp_tim[k] = {k[0], 1'b0, k == 20};
      end
      tick();
      if (k < 40) chk("xpos_d1", {21'h0, xpos_o}, 32'(96 + k));
      if (k >= 2) begin
        chk($sformatf("scan_rgb_x%0d", 94 + k), {8'h0, r_o, g_o, b_o}, {8'h0, exp_rgb[k-2]});
        chk($sformatf("scan_tim_x%0d", 94 + k), {29'h0, hsync_o, vsync_o, blank_o},
            {29'h0, exp_tim[k-2]});
      end
    end
    hsync_i = 1'b0; blank_i = 1'b0;

    // Address mapping unflipped, then mirrored
    xpos_i = 11'd103; ypos_i = 10'd52; #1;
    chk("adr_plain", {22'h0, spradr_o[9:0]}, {22'h0, 5'd2, 5'd3});
    hflip_i = 4'b0001; vflip_i = 4'b0001;
    vs_pulse();
    xpos_i = 11'd100; ypos_i = 10'd50; #1;
    chk("adr_flip_edge", {22'h0, spradr_o[9:0]}, {22'h0, 5'd31, 5'd31});
    xpos_i = 11'd131; ypos_i = 10'd52; #1;
    chk("adr_flip_far", {22'h0, spradr_o[9:0]}, {22'h0, 5'd29, 5'd0});
    hflip_i = '0; vflip_i = '0;

    // Overlap of sprites 0 and 1: priority and collision
    ram_val[1] = 16'h83E0;
    spren_i = 4'b0011;
    sprx_i[XCNTW +: XCNTW] = 11'd100;
    spry_i[YCNTW +: YCNTW] = 10'd50;
    vs_pulse();
    chk("coll_before", {27'h0, coll_o, irq_o}, 32'h0);
    pix("prio_s0", 110, 50, RED);
    chk("coll_set", {27'h0, coll_o, irq_o}, {27'h0, 4'b0011, 1'b1});
    swapcolor_i = 3'b011;
    pix("swapcolor", 110, 50, 24'hFFFFFF);
    swapcolor_i = 3'b000;
    pix("off_sprite", 10, 50, BG);
    coll_clr_i = 1'b1; tick(); coll_clr_i = 1'b0;
    chk("coll_clr", {27'h0, coll_o, irq_o}, 32'h0);
    blank_i = 1'b1;
    pix("blank_black", 110, 50, 24'h0);
    chk("coll_blank", {27'h0, coll_o, irq_o}, 32'h0);
    blank_i = 1'b0;
    pix("prio_again", 110, 50, RED);
    chk("coll_reset", {27'h0, coll_o, irq_o}, {27'h0, 4'b0011, 1'b1});
    coll_clr_i = 1'b1; xpos_i = 11'd10; tick(); coll_clr_i = 1'b0;

    // Mid-frame position change waits for the vsync rise
    spren_i = 4'b0001;
    vs_pulse();
    sprx_i[0 +: XCNTW] = 11'd200;
    pix("old_pos_held", 110, 50, RED);
    pix("new_pos_wait", 210, 50, BG);
    vs_pulse();
    pix("old_pos_gone", 110, 50, BG);
    pix("new_pos_live", 210, 50, RED);
    pix("right_edge_out", 232, 50, BG);
    pix("right_edge_in", 231, 50, RED);

    // Transparent pixel passes background
    ram_val[0] = 16'h7FFF;
    pix("transparent", 210, 50, BG);
    ram_val[0] = 16'hFC00;

    // Asynchronous reset mid-line
    pix("pre_reset", 210, 50, RED);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {8'h0, r_o, g_o, b_o}, 32'h0);
    chk("async_rst_misc", {xpos_o, ypos_o, hsync_o, vsync_o, blank_o, coll_o, irq_o},
        {XCNTW'(0), YCNTW'(0), 3'b0, 4'b0, 1'b0});
    #3 rst_n = 1'b1;
    pix("post_rst_disabled", 210, 50, BG);
    vs_pulse();
    pix("post_rst_vsync", 210, 50, RED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1);
  end

endmodule
